// File: rtl/shared_bus_arbiter.sv
// shared_bus_arbiter
//   Round-robin arbiter and transfer sequencer for the shared bus. One
//   requester at a time owns the bus and streams words to the consumer over
//   a valid/ready handshake. Each ownership ends with one dead cycle (TURN),
//   so two different requesters are never granted on adjacent cycles.
//
// Ports
//   clk, rst      bus clock, synchronous active-high reset
//   req[NREQ]     per-requester request / word qualifier while granted
//   last[NREQ]    per-requester end-of-burst marker
//   wdata         requester words, requester i at [i*DATA_W +: DATA_W]
//   gnt[NREQ]     one-hot grant, zero outside OWN
//   owner         current (or most recent) owner index
//   busy          high while in OWN
//   bus_data      shared bus word, zero when bus_valid is low
//   bus_valid     word on bus is valid
//   bus_ready     consumer accepts the word

// Per-requester slice: owner decode and masked word/qualifiers.
module shared_bus_arbiter_lane #(
  parameter int OW     = 2,
  parameter int IDX    = 0,
  parameter int DATA_W = 64
) (
  input  logic [OW-1:0]     owner,
  input  logic              req,
  input  logic              last,
  input  logic [DATA_W-1:0] wdata,
  output logic              sel,
  output logic              req_m,
  output logic              last_m,
  output logic [DATA_W-1:0] data_m
);
  always_comb begin
    sel    = (owner == OW'(IDX));
    req_m  = sel & req;
    last_m = sel & last;
    data_m = sel ? wdata : '0;
  end
endmodule

module shared_bus_arbiter #(
  parameter int NREQ      = 3,
  parameter int DATA_W    = 64,
  parameter int MAX_BEATS = 8,
  localparam int OW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        last,
  input  logic [NREQ*DATA_W-1:0] wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [OW-1:0]          owner,
  output logic                   busy,
  output logic [DATA_W-1:0]      bus_data,
  output logic                   bus_valid,
  input  logic                   bus_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_TURN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;

  // ---------------------------------------------------------------------
  // Per-lane owner decode and mux, OR-reduced into owner's view
  // ---------------------------------------------------------------------
  logic [NREQ-1:0]             own_oh;
  logic [NREQ-1:0]             req_m, last_m;
  logic [NREQ-1:0][DATA_W-1:0] data_m;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    shared_bus_arbiter_lane #(
      .OW(OW), .IDX(i), .DATA_W(DATA_W)
    ) u_lane (
      .owner  (owner_q),
      .req    (req[i]),
      .last   (last[i]),
      .wdata  (wdata[i*DATA_W +: DATA_W]),
      .sel    (own_oh[i]),
      .req_m  (req_m[i]),
      .last_m (last_m[i]),
      .data_m (data_m[i])
    );
  end

  logic              own_req, own_last;
  logic [DATA_W-1:0] own_data;

  always_comb begin
    own_req  = |req_m;
    own_last = |last_m;
    own_data = '0;
    for (int i = 0; i < NREQ; i++) own_data = own_data | data_m[i];
  end

  // ---------------------------------------------------------------------
  // Round-robin pick: first set req searching upward from ptr+1, wrapping.
  // The inner loop matches the rotated index against a constant lane so
  // every req select uses an elaborated index.
  // ---------------------------------------------------------------------
  logic          pick_found;
  logic [OW-1:0] pick_idx;

  always_comb begin
    int idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (!pick_found && (i == idx) && req[i]) begin
          pick_found = 1'b1;
          pick_idx   = OW'(i);
        end
      end
    end
  end

  // Transfer and release conditions in OWN
  logic xfer, limit_hit;

  always_comb begin
    xfer      = (state_q == S_OWN) & own_req & bus_ready;
    // 9-bit compare so a count of 255 never wraps into a false match
    limit_hit = (({1'b0, beat_cnt_q} + 9'd1) == 9'(MAX_BEATS));
  end

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= '0;
      ptr_q      <= OW'(NREQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d    = S_OWN;
          owner_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end
      S_OWN: begin
        if (!own_req) begin
          // Dropping req forfeits the grant; nothing transfers
          state_d = S_TURN;
          ptr_d   = owner_q;
        end else if (xfer) begin
          beat_cnt_d = (beat_cnt_q == 8'hFF) ? beat_cnt_q : beat_cnt_q + 8'd1;
          if (own_last || limit_hit) begin
            state_d = S_TURN;
            ptr_d   = owner_q;
          end
        end
      end
      S_TURN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  always_comb begin
    busy      = (state_q == S_OWN);
    gnt       = busy ? own_oh : '0;
    owner     = owner_q;
    bus_valid = busy & own_req;
    bus_data  = bus_valid ? own_data : '0;
  end

endmodule
